// File: rtl/fx_alu_pipe.sv
// fx_alu_pipe: two-stage pipelined fixed-point ALU (add, sub, mul, mac)
// for Q(WIDTH-FRAC).FRAC two's-complement operands, with valid/ready flow control.
// Optional feature macro: FX_SAT_EN. When defined, overflowed results clamp
// to the most-positive or most-negative value according to their true sign.
// When undefined, overflowed results wrap.
module fx_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] din_1,
  input  logic [WIDTH-1:0] din_2,
  input  logic [1:0]       i_op,
  input  logic             i_acc_clr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] dout,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_e;

`ifdef FX_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Stage 1 registers.
  logic                      s1_valid;
  op_e                       s1_op;
  logic                      s1_clr;
  logic [WIDTH-1:0]          s1_a;
  logic [WIDTH-1:0]          s1_b;
  logic signed [2*WIDTH-1:0] s1_prod;

  // Accumulator register.
  logic [WIDTH-1:0] acc;

  // Stage 2 result logic.
  logic                      en;
  logic [WIDTH:0]            a_ext;
  logic [WIDTH:0]            b_ext;
  logic [WIDTH:0]            addsub;
  logic [WIDTH:0]            mac_sum;
  logic [WIDTH:0]            sum_sel;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      p_ovf;
  logic [WIDTH-1:0]          p_res;
  logic                      use_sum;
  logic                      sum_ovf;
  logic [WIDTH-1:0]          res;
  logic                      ovf;

  // The whole pipeline advances together, or it stalls together.
  assign en      = i_ready || !o_valid;
  assign o_ready = en;

  // Form the stage-2 result and the overflow flag from the stage-1 contents
  // and the current accumulator.
  always_comb begin
    a_ext   = {s1_a[WIDTH-1], s1_a};
    b_ext   = {s1_b[WIDTH-1], s1_b};
    addsub  = (s1_op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    shifted = s1_prod >>> FRAC;
    p_ovf   = (shifted[2*WIDTH-1:WIDTH-1] != '0) && (shifted[2*WIDTH-1:WIDTH-1] != '1);
    p_res   = shifted[WIDTH-1:0];
`ifdef FX_SAT_EN
    if (p_ovf) p_res = shifted[2*WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
    // The mac beat adds the fixed-up product, which is clamped or wrapped,
    // so that the stored accumulator always holds a representable value.
    mac_sum = (s1_clr ? '0 : {acc[WIDTH-1], acc}) + {p_res[WIDTH-1], p_res};
    use_sum = 1'b1;
    sum_sel = addsub;
    ovf     = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB: sum_sel = addsub;
      OP_MUL:         use_sum = 1'b0;
      OP_MAC: begin
        sum_sel = mac_sum;
        ovf     = p_ovf;
      end
      default:        sum_sel = addsub;
    endcase
    sum_ovf = sum_sel[WIDTH] ^ sum_sel[WIDTH-1];
    if (use_sum) begin
      res = sum_sel[WIDTH-1:0];
      ovf = ovf | sum_ovf;
`ifdef FX_SAT_EN
      if (sum_ovf) res = sum_sel[WIDTH] ? MIN_NEG : MAX_POS;
`endif
    end else begin
      res = p_res;
      ovf = p_ovf;
    end
  end

  // Pipeline registers and the accumulator. A synchronous reset clears all
  // of them, and any beat in flight is discarded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_clr   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prod  <= '0;
      o_valid  <= 1'b0;
      dout     <= '0;
      o_ovf    <= 1'b0;
      acc      <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_op   <= op_e'(i_op);
        s1_clr  <= i_acc_clr;
        s1_a    <= din_1;
        s1_b    <= din_2;
        s1_prod <= $signed({{WIDTH{din_1[WIDTH-1]}}, din_1}) *
                   $signed({{WIDTH{din_2[WIDTH-1]}}, din_2});
      end
      o_valid <= s1_valid;
      if (s1_valid) begin
        dout  <= res;
        o_ovf <= ovf;
        if (s1_op == OP_MAC) acc <= res;
      end
    end
  end

endmodule

// File: tb/tb_fx_alu_pipe.sv
// Directed testbench for fx_alu_pipe (WIDTH=32, FRAC=16). The expected
// values depend on whether FX_SAT_EN is defined.
module tb_fx_alu_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] din_1 = '0;
  logic [31:0] din_2 = '0;
  logic [1:0]  i_op = 2'b00;
  logic        i_acc_clr = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] dout;
  logic        o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, MAC = 2'b11;

  fx_alu_pipe #(.WIDTH(32), .FRAC(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .din_1(din_1), .din_2(din_2), .i_op(i_op), .i_acc_clr(i_acc_clr),
    .o_valid(o_valid), .i_ready(i_ready), .dout(dout), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one beat, or an idle cycle, then advance past the next rising edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic clr);
    i_valid = v; din_1 = a; din_2 = b; i_op = op; i_acc_clr = clr;
    @(posedge i_clk); #1;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] exp, input logic exp_ovf);
    chk({tag, ".valid"}, {31'b0, o_valid}, 32'd1);
    chk({tag, ".dout"}, dout, exp);
    chk({tag, ".ovf"}, {31'b0, o_ovf}, {31'b0, exp_ovf});
  endtask

  initial begin : main
    logic [31:0] exp_q [4];
    logic [31:0] held;
    int sent, recv;
    bit stalled;

    // Reset.
    step(0, 0, 0, ADD, 0);
    step(0, 0, 0, ADD, 0);
    i_rst = 1'b0;
    chk("rst.valid", {31'b0, o_valid}, 32'd0);
    chk("rst.dout", dout, 32'd0);
    chk("rst.ovf", {31'b0, o_ovf}, 32'd0);
    chk("rst.ready", {31'b0, o_ready}, 32'd1);

    // Back-to-back add, then mul. The result appears after the second edge.
    step(1, 32'h00010000, 32'h00020000, ADD, 0);
    chk("lat.notyet", {31'b0, o_valid}, 32'd0);
    step(1, 32'h00018000, 32'h00020000, MUL, 0);
    chk_res("add1", 32'h00030000, 1'b0);
    step(0, 0, 0, ADD, 0);
    chk_res("mul1", 32'h00030000, 1'b0);
    step(0, 0, 0, ADD, 0);
    chk("idle.valid", {31'b0, o_valid}, 32'd0);

    // Signed multiply rounds toward negative infinity. Signed subtraction.
    step(1, 32'hFFFF0000, 32'h00008000, MUL, 0);
    step(1, 32'hFFFFFFFF, 32'h00008000, MUL, 0);
    chk_res("mulneg", 32'hFFFF8000, 1'b0);
    step(1, 32'h00010000, 32'h00030000, SUB, 0);
    chk_res("mulfloor", 32'hFFFFFFFF, 1'b0);
    step(1, 32'h7FFFFFFF, 32'h00000000, ADD, 0);
    chk_res("sub", 32'hFFFE0000, 1'b0);

    // Overflow cases. The first check here is the largest value that does not overflow.
    step(1, 32'h7FFF0000, 32'h00020000, ADD, 0);
    chk_res("addmax", 32'h7FFFFFFF, 1'b0);
    step(1, 32'h01000000, 32'h01000000, MUL, 0);
`ifdef FX_SAT_EN
    chk_res("addovf", 32'h7FFFFFFF, 1'b1);
`else
    chk_res("addovf", 32'h80010000, 1'b1);
`endif
    step(1, 32'h80000000, 32'h00010000, SUB, 0);
`ifdef FX_SAT_EN
    chk_res("mulovf", 32'h7FFFFFFF, 1'b1);
`else
    chk_res("mulovf", 32'h00000000, 1'b1);
`endif
    step(0, 0, 0, ADD, 0);
`ifdef FX_SAT_EN
    chk_res("subovf", 32'h80000000, 1'b1);
`else
    chk_res("subovf", 32'h7FFF0000, 1'b1);
`endif

    // MAC chain with back-to-back mac beats and an intervening add.
    step(1, 32'h00020000, 32'h00030000, MAC, 1);
    step(1, 32'h00010000, 32'h00008000, MAC, 0);
    chk_res("mac1", 32'h00060000, 1'b0);
    step(1, 32'h00010000, 32'h00010000, ADD, 0);
    chk_res("mac2", 32'h00068000, 1'b0);
    step(1, 32'h00010000, 32'h00010000, MAC, 0);
    chk_res("macadd", 32'h00020000, 1'b0);
    step(0, 0, 0, ADD, 0);
    chk_res("mac3", 32'h00078000, 1'b0);
    step(0, 0, 0, ADD, 0);

    // Backpressure: stream four beats while i_ready is low for three cycles.
    for (int k = 0; k < 4; k++) exp_q[k] = 32'h00000100 + 32'(k + 1);
    sent = 0; recv = 0; stalled = 0; held = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      i_ready   = !(cyc >= 2 && cyc <= 4);
      i_valid   = (sent < 4);
      din_1     = 32'(sent + 1);
      din_2     = 32'h00000100;
      i_op      = ADD;
      i_acc_clr = 1'b0;
      #1;
      if (o_valid && !i_ready) begin
        chk("bp.ready_low", {31'b0, o_ready}, 32'd0);
        if (!stalled) held = dout;
        else chk("bp.hold", dout, held);
        stalled = 1;
      end
      if (o_valid && i_ready) begin
        if (recv < 4) chk($sformatf("bp.beat%0d", recv), dout, exp_q[recv]);
        else chk("bp.extra", {31'b0, o_valid}, 32'd0);
        recv++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    chk("bp.count", 32'(recv), 32'd4);
    chk("bp.stalled", {31'b0, stalled}, 32'd1);

    // Reset in mid-stream with two beats in flight. The accumulator must clear.
    step(1, 32'h00010000, 32'h00010000, ADD, 0);
    step(1, 32'h00010000, 32'h00010000, MAC, 0);
    chk("pre_rst.valid", {31'b0, o_valid}, 32'd1);
    i_rst = 1'b1;
    step(1, 32'h00010000, 32'h00010000, ADD, 0);
    i_rst = 1'b0;
    chk("midrst.valid", {31'b0, o_valid}, 32'd0);
    chk("midrst.dout", dout, 32'd0);
    step(0, 0, 0, ADD, 0);
    chk("midrst.flush", {31'b0, o_valid}, 32'd0);
    step(1, 32'h00010000, 32'h00020000, MAC, 0);
    step(0, 0, 0, ADD, 0);
    chk_res("macafterrst", 32'h00020000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
